// File: rtl/cam_pkg.sv
// Shared camera-pipeline types and constants used by the capture stage and the tracker.
package cam_pkg;

    localparam int unsigned FRAME_W_DEF = 640;
    localparam int unsigned FRAME_H_DEF = 480;

    // Bounds reported by the capture stage when no pixel matched during the frame
    localparam logic [9:0] BOX_EMPTY_MIN = 10'd641;
    localparam logic [9:0] BOX_EMPTY_MAX = 10'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_FILTER,
        S_PUBLISH
    } tracker_state_e;

    typedef struct packed {
        logic [9:0] min_x;
        logic [9:0] max_x;
        logic [9:0] min_y;
        logic [9:0] max_y;
    } bbox_t;

endpackage

// File: rtl/iir_shift_filter.sv
// One-axis first-order IIR: snap loads the new value, en moves filt by (new - filt) >>> ALPHA_SHIFT.
module iir_shift_filter #(
    parameter int unsigned ALPHA_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       snap,
    input  logic       en,
    input  logic [9:0] new_val,
    output logic [9:0] filt
);

    logic [9:0]        filt_q, filt_d;
    logic signed [10:0] diff;
    logic signed [10:0] step;

    always_comb begin
        diff   = $signed({1'b0, new_val}) - $signed({1'b0, filt_q});
        step   = diff >>> ALPHA_SHIFT;
        filt_d = filt_q;
        if (snap) begin
            filt_d = new_val;
        end else if (en) begin
            // step lies between 0 and diff, so the 10-bit wrap-around add never overflows
            filt_d = filt_q + step[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/bbox_tracker.sv
// Samples the capture-stage bounding box at each vsync rise, validates it, smooths its centre
// and publishes one per-frame result on a valid/ready interface.
module bbox_tracker
    import cam_pkg::*;
#(
    parameter int unsigned FRAME_W     = FRAME_W_DEF,
    parameter int unsigned FRAME_H     = FRAME_H_DEF,
    parameter int unsigned MIN_AREA    = 64,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned LOST_FRAMES = 4
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic [9:0] min_x,
    input  logic [9:0] max_x,
    input  logic [9:0] min_y,
    input  logic [9:0] max_y,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [9:0] cx,
    output logic [9:0] cy,
    output logic [9:0] box_w,
    output logic [9:0] box_h,
    output logic       locked,
    output logic       det,
    output logic       overrun
);

    localparam int unsigned MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOST_FRAMES);

    tracker_state_e state_q, state_d;
    logic           vsync_q;
    logic           vs_rise;
    logic           do_sample, do_check, do_filter, do_publish;

    bbox_t          raw_q;
    logic [9:0]     w_c, h_c;
    logic [19:0]    area_c;
    logic [10:0]    sum_x_c, sum_y_c;
    logic           valid_c;

    logic           valid_q;
    logic [9:0]     w_q, h_q, ncx_q, ncy_q;

    logic           trk_locked_q, trk_det_q;
    logic [9:0]     trk_w_q, trk_h_q;
    logic [MISS_W-1:0] miss_q, miss_inc;
    logic [9:0]     filt_x, filt_y;
    logic           f_snap, f_en;

    logic           out_valid_q, locked_q, det_q, overrun_q;
    logic [9:0]     cx_q, cy_q, box_w_q, box_h_q;

    assign vs_rise = vsync & ~vsync_q;

    always_comb begin
        state_d    = state_q;
        do_sample  = 1'b0;
        do_check   = 1'b0;
        do_filter  = 1'b0;
        do_publish = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (vs_rise) begin
                    do_sample = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                do_check = 1'b1;
                state_d  = S_FILTER;
            end
            S_FILTER: begin
                do_filter = 1'b1;
                state_d   = S_PUBLISH;
            end
            S_PUBLISH: begin
                do_publish = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
        end
    end

    always_comb begin
        w_c     = raw_q.max_x - raw_q.min_x;
        h_c     = raw_q.max_y - raw_q.min_y;
        area_c  = 20'(w_c) * 20'(h_c);
        sum_x_c = {1'b0, raw_q.min_x} + {1'b0, raw_q.max_x};
        sum_y_c = {1'b0, raw_q.min_y} + {1'b0, raw_q.max_y};
        valid_c = (raw_q.min_x <= raw_q.max_x) && (raw_q.min_y <= raw_q.max_y) &&
                  (raw_q.max_x < 10'(FRAME_W)) && (raw_q.max_y < 10'(FRAME_H)) &&
                  (area_c >= 20'(MIN_AREA));
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q   <= '0;
            valid_q <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            ncx_q   <= '0;
            ncy_q   <= '0;
        end else begin
            if (do_sample) begin
                raw_q <= '{min_x: min_x, max_x: max_x, min_y: min_y, max_y: max_y};
            end
            if (do_check) begin
                valid_q <= valid_c;
                w_q     <= w_c;
                h_q     <= h_c;
                ncx_q   <= sum_x_c[10:1];
                ncy_q   <= sum_y_c[10:1];
            end
        end
    end

    assign f_snap   = do_filter & valid_q & ~trk_locked_q;
    assign f_en     = do_filter & valid_q & trk_locked_q;
    assign miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;

    iir_shift_filter #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_filt_x (
        .clk    (pclk),
        .rst_n  (reset_n),
        .snap   (f_snap),
        .en     (f_en),
        .new_val(ncx_q),
        .filt   (filt_x)
    );

    iir_shift_filter #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_filt_y (
        .clk    (pclk),
        .rst_n  (reset_n),
        .snap   (f_snap),
        .en     (f_en),
        .new_val(ncy_q),
        .filt   (filt_y)
    );

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            trk_locked_q <= 1'b0;
            trk_det_q    <= 1'b0;
            trk_w_q      <= '0;
            trk_h_q      <= '0;
            miss_q       <= '0;
        end else if (do_filter) begin
            trk_det_q <= valid_q;
            if (valid_q) begin
                trk_locked_q <= 1'b1;
                miss_q       <= '0;
                trk_w_q      <= w_q;
                trk_h_q      <= h_q;
            end else begin
                miss_q <= miss_inc;
                if (miss_inc == MISS_MAX) begin
                    trk_locked_q <= 1'b0;
                end
            end
        end
    end

    // A publish load takes priority over a same-cycle handshake, so out_valid stays set
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            box_w_q     <= '0;
            box_h_q     <= '0;
            locked_q    <= 1'b0;
            det_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (do_publish) begin
                out_valid_q <= 1'b1;
                cx_q        <= filt_x;
                cy_q        <= filt_y;
                box_w_q     <= trk_w_q;
                box_h_q     <= trk_h_q;
                locked_q    <= trk_locked_q;
                det_q       <= trk_det_q;
                if (out_valid_q && !out_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (vs_rise && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign cx        = cx_q;
    assign cy        = cy_q;
    assign box_w     = box_w_q;
    assign box_h     = box_h_q;
    assign locked    = locked_q;
    assign det       = det_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_bbox_tracker.sv
// Self-checking bench for bbox_tracker: directed frame table, randomized frames against a
// behavioural tracker model, backpressure, frame drop and asynchronous reset sequences.
module tb_bbox_tracker;
    import cam_pkg::*;

    logic       pclk      = 1'b0;
    logic       reset_n   = 1'b0;
    logic       vsync     = 1'b0;
    logic       out_ready = 1'b0;
    logic [9:0] min_x = '0, max_x = '0, min_y = '0, max_y = '0;
    logic       out_valid, locked, det, overrun;
    logic [9:0] cx, cy, box_w, box_h;

    bbox_tracker #(
        .FRAME_W    (640),
        .FRAME_H    (480),
        .MIN_AREA   (64),
        .ALPHA_SHIFT(2),
        .LOST_FRAMES(4)
    ) dut (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .vsync    (vsync),
        .min_x    (min_x),
        .max_x    (max_x),
        .min_y    (min_y),
        .max_y    (max_y),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .cx       (cx),
        .cy       (cy),
        .box_w    (box_w),
        .box_h    (box_h),
        .locked   (locked),
        .det      (det),
        .overrun  (overrun)
    );

    always #5 pclk = ~pclk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model of the tracker, one call per published frame
    int m_fx, m_fy, m_w, m_h, m_miss, m_locked, m_det;

    task automatic model_reset();
        m_fx = 0; m_fy = 0; m_w = 0; m_h = 0; m_miss = 0; m_locked = 0; m_det = 0;
    endtask

    function automatic int floor_div4(input int d);
        return (d >= 0) ? d / 4 : -((3 - d) / 4);
    endfunction

    task automatic model_step(input int ax, input int bx, input int ay, input int by);
        int w, h, nx, ny;
        bit v;
        w  = bx - ax;
        h  = by - ay;
        v  = (ax <= bx) && (ay <= by) && (bx < 640) && (by < 480) && (w * h >= 64);
        nx = (ax + bx) / 2;
        ny = (ay + by) / 2;
        m_det = v ? 1 : 0;
        if (v) begin
            if (m_locked == 0) begin
                m_fx = nx;
                m_fy = ny;
            end else begin
                m_fx = m_fx + floor_div4(nx - m_fx);
                m_fy = m_fy + floor_div4(ny - m_fy);
            end
            m_locked = 1;
            m_miss   = 0;
            m_w      = w;
            m_h      = h;
        end else begin
            if (m_miss < 4) m_miss++;
            if (m_miss == 4) m_locked = 0;
        end
    endtask

    task automatic cmp_out(input string tag, input int ecx, input int ecy, input int ew,
                           input int eh, input int el, input int ed);
        chk({tag, ".cx"},     int'(cx),     ecx);
        chk({tag, ".cy"},     int'(cy),     ecy);
        chk({tag, ".box_w"},  int'(box_w),  ew);
        chk({tag, ".box_h"},  int'(box_h),  eh);
        chk({tag, ".locked"}, int'(locked), el);
        chk({tag, ".det"},    int'(det),    ed);
    endtask

    task automatic cmp_model(input string tag);
        cmp_out(tag, m_fx, m_fy, m_w, m_h, m_locked, m_det);
    endtask

    // Pulse vsync with the given box; out_valid must appear exactly 3 edges after sampling
    task automatic run_frame(input string tag, input int ax, input int bx, input int ay,
                             input int by, input bit chk_early);
        @(negedge pclk);
        min_x = 10'(ax); max_x = 10'(bx); min_y = 10'(ay); max_y = 10'(by);
        vsync = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            if (k == 2) vsync = 1'b0;
            if (k == 3 && chk_early) chk({tag, ".early_valid"}, int'(out_valid), 0);
        end
        chk({tag, ".out_valid"}, int'(out_valid), 1);
        model_step(ax, bx, ay, by);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge pclk);
        chk({tag, ".hs_clear"}, int'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int ax, bx, ay, by;
        int ecx, ecy, ew, eh, el, ed;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int ax, bx, ay, by, sel, seen;

        tbl = '{
            '{100, 140,  50,  90, 120,  70,  40,  40, 1, 1},
            '{180, 220,  50,  90, 140,  70,  40,  40, 1, 1},
            '{ 20,  60,  50,  90, 115,  70,  40,  40, 1, 1},
            '{300, 304, 300, 304, 115,  70,  40,  40, 1, 0},
            '{641,   0, 641,   0, 115,  70,  40,  40, 1, 0},
            '{641,   0, 641,   0, 115,  70,  40,  40, 1, 0},
            '{641,   0, 641,   0, 115,  70,  40,  40, 0, 0},
            '{641,   0, 641,   0, 115,  70,  40,  40, 0, 0},
            '{400, 500, 200, 300, 450, 250, 100, 100, 1, 1},
            '{600, 640, 200, 300, 450, 250, 100, 100, 1, 0},
            '{400, 500, 200, 480, 450, 250, 100, 100, 1, 0},
            '{ 10,  17,  10,  18, 450, 250, 100, 100, 1, 0},
            '{ 10,  18,  10,  18, 341, 191,   8,   8, 1, 1},
            '{  0, 639,   0, 479, 335, 203, 639, 479, 1, 1}
        };

        repeat (3) @(negedge pclk);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.overrun",   int'(overrun),   0);
        cmp_out("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_frame(tag, tbl[i].ax, tbl[i].bx, tbl[i].ay, tbl[i].by, 1'b1);
            cmp_out(tag, tbl[i].ecx, tbl[i].ecy, tbl[i].ew, tbl[i].eh, tbl[i].el, tbl[i].ed);
            handshake(tag);
        end
        chk("table.overrun", int'(overrun), 0);

        for (int i = 0; i < 60; i++) begin
            string tag;
            tag = $sformatf("rnd%0d", i);
            sel = int'($urandom_range(0, 4));
            case (sel)
                0, 1: begin
                    ax = int'($urandom_range(0, 630)); bx = int'($urandom_range(ax, 639));
                    ay = int'($urandom_range(0, 470)); by = int'($urandom_range(ay, 479));
                end
                2: begin
                    ax = int'(BOX_EMPTY_MIN); bx = int'(BOX_EMPTY_MAX);
                    ay = int'(BOX_EMPTY_MIN); by = int'(BOX_EMPTY_MAX);
                end
                3: begin
                    ax = int'($urandom_range(0, 600)); bx = ax + int'($urandom_range(0, 12));
                    ay = int'($urandom_range(0, 450)); by = ay + int'($urandom_range(0, 12));
                end
                default: begin
                    ax = int'($urandom_range(0, 1023)); bx = int'($urandom_range(0, 1023));
                    ay = int'($urandom_range(0, 1023)); by = int'($urandom_range(0, 1023));
                end
            endcase
            run_frame(tag, ax, bx, ay, by, 1'b1);
            cmp_model(tag);
            handshake(tag);
        end

        // Backpressure: second frame overwrites the first unacknowledged result
        run_frame("bp_a", 100, 140, 50, 90, 1'b1);
        chk("bp_a.overrun", int'(overrun), 0);
        run_frame("bp_b", 200, 260, 100, 180, 1'b0);
        cmp_model("bp_b");
        chk("bp_b.overrun", int'(overrun), 1);
        handshake("bp_b");
        chk("bp_b.overrun_sticky", int'(overrun), 1);

        // Asynchronous reset while the FSM sits in S_FILTER
        @(negedge pclk);
        min_x = 10'd100; max_x = 10'd140; min_y = 10'd50; max_y = 10'd90;
        vsync = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        chk("rst.pre_state", int'(dut.state_q), int'(S_FILTER));
        reset_n = 1'b0;
        #1;
        chk("rst.state", int'(dut.state_q), int'(S_IDLE));
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.overrun", int'(overrun), 0);
        cmp_out("rst", 0, 0, 0, 0, 0, 0);
        vsync = 1'b0;
        model_reset();
        @(negedge pclk);
        reset_n = 1'b1;

        // Long vsync-high period: exactly one result
        out_ready = 1'b1;
        @(negedge pclk);
        vsync = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (out_valid) seen++;
        end
        vsync = 1'b0;
        chk("long_vs.results", seen, 1);
        model_step(100, 140, 50, 90);
        cmp_model("long_vs");
        chk("long_vs.overrun", int'(overrun), 0);

        // A second vsync rise while the frame is in flight is dropped
        @(negedge pclk);
        min_x = 10'd200; max_x = 10'd300; min_y = 10'd100; max_y = 10'd200;
        vsync = 1'b1;
        @(negedge pclk);
        vsync = 1'b0;
        min_x = 10'd0; max_x = 10'd639; min_y = 10'd0; max_y = 10'd479;
        @(negedge pclk);
        vsync = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            if (k == 0) vsync = 1'b0;
            if (out_valid) seen++;
        end
        chk("drop.results", seen, 1);
        chk("drop.overrun", int'(overrun), 1);
        model_step(200, 300, 100, 200);
        cmp_model("drop");
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
